balance_pid: RTL and testbench
==============================

BALANCE_PID -- requirements
Module: balance_pid

Interface
REQ-001 P_COEFF, 12, unsigned 5-bit proportional gain.
REQ-002 D_COEFF, 20, unsigned 6-bit derivative gain.
REQ-003 clk  input  1  system clock, 50 MHz, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 vld  input  1  one-cycle pulse from the inertial interface; new ptch valid this cycle.
REQ-006 ptch  input  16  signed fusion-corrected pitch.
REQ-007 pwr_up  input  1  level; high = balance loop enabled.
REQ-008 rider_off  input  1  level; high = no rider, integrator held at zero.
REQ-009 PID_cntrl  output  12  signed registered control word for the motor drive.
REQ-010 PID_vld  output  1  one-cycle pulse; PID_cntrl updated this cycle.

Function
REQ-011 err_sat SHALL be ptch saturated to 10-bit signed, range -512..+511.
REQ-012 P_term SHALL be err_sat * P_COEFF, signed 15-bit.
REQ-013 integ SHALL be an 18-bit signed accumulator: on a vld cycle, integ <= integ + sign-extended err_sat.
REQ-014 On signed overflow (both operands same sign, result opposite sign), integ SHALL hold its value.
REQ-015 rider_off high or pwr_up low SHALL force integ to 0 on the next edge; this overrides vld.
REQ-016 I_term SHALL be the post-update integ arithmetically shifted right by 6, giving 12-bit signed.
REQ-017 prev_err SHALL register err_sat on each vld. It resets to 0 and is cleared when pwr_up is low.
REQ-018 D_diff SHALL be err_sat - prev_err (11-bit), saturated to -64..+63.
REQ-019 D_term SHALL be D_diff * D_COEFF, signed 13-bit.
REQ-020 ss_cnt SHALL be an 8-bit soft-start counter:
- increments on each vld while pwr_up is high;
- saturates at 255;
- clears when pwr_up is low.
REQ-021 Pipeline stage 1, on the edge ending the vld cycle, SHALL register:
- P_term, I_term, D_term;
- the pre-increment ss_cnt.
REQ-022 Pipeline stage 2, one edge later, SHALL:
- sum the three terms sign-extended to 16 bits;
- saturate the sum to 12-bit signed (-2048..+2047);
- clamp to +/-(ss_cnt_captured*8);
- register the result into PID_cntrl.
REQ-023 Latency: PID_vld SHALL be high exactly 2 cycles after the vld cycle. PID_cntrl SHALL change only on the edge that raises PID_vld.
REQ-024 Back-to-back vld on consecutive cycles SHALL be accepted, each producing its own PID_vld 2 cycles later.
REQ-025 vld while pwr_up is low SHALL produce PID_vld with PID_cntrl = 0.
REQ-026 The block SHALL have no other states; the pipeline is a fixed two-stage shift of a valid bit.

Reset
REQ-027 While rst is high, the following SHALL all be 0 immediately, regardless of clk:
- integ, prev_err, ss_cnt;
- all pipeline registers and the valid bits;
- PID_cntrl and PID_vld.
REQ-028 rst asserted mid-pipeline SHALL discard in-flight results; no PID_vld after release.
REQ-029 The first vld on or after the first edge following rst release SHALL be processed normally.

Verification
REQ-030 Steady state: pwr_up=1, 255 vld with ptch=0, then vld with ptch=0x0010 -> PID_cntrl=512 (P=192, I=0, D=320), PID_vld 2 cycles later.
REQ-031 Soft start: after rst, pwr_up=1, two vld with ptch=0x0010 -> first PID_cntrl=0, second PID_cntrl=8 (sum 192 clamped to 8).
REQ-032 Saturation: ss_cnt=255, prev_err=0, ptch=0x7FFF -> PID_cntrl=2040. Then after re-zeroing, ptch=0x8000 -> PID_cntrl=-2040.
REQ-033 Integrator overflow: rider_off=0, 257 vld with ptch=0x01FF -> integ holds 130816, I_term=2044, no sign flip.
REQ-034 rider_off=1 for one cycle with integ=130816 -> integ=0 next edge; next vld with ptch=0 gives I_term=0.
REQ-035 rst pulsed 1 cycle after vld -> PID_vld never asserts; all outputs 0 during and after rst.

Source files
------------

// File: rtl/balance_pid_if.sv
// Control-loop handshake between the inertial front end and the balance PID.
// The master drives the pitch samples and enables; the slave returns the control word.
interface balance_pid_if;
    logic               vld;
    logic signed [15:0] ptch;
    logic               pwr_up;
    logic               rider_off;
    logic signed [11:0] PID_cntrl;
    logic               PID_vld;

    modport master (
        output vld,
        output ptch,
        output pwr_up,
        output rider_off,
        input  PID_cntrl,
        input  PID_vld
    );

    modport slave (
        input  vld,
        input  ptch,
        input  pwr_up,
        input  rider_off,
        output PID_cntrl,
        output PID_vld
    );
endinterface

// File: rtl/balance_pid.sv
// Balance-loop PID: saturated pitch error feeds P, I and D terms, a two-stage pipeline
// sums them and applies a soft-start clamp that widens with each accepted sample.
module balance_pid #(
    parameter logic [4:0] P_COEFF = 5'd12,
    parameter logic [5:0] D_COEFF = 6'd20
) (
    input logic         clk,
    input logic         rst,
    balance_pid_if.slave bus
);

    logic signed [15:0] ptch;
    logic               vld;
    logic               pwr_up;
    logic               rider_off;

    assign ptch      = bus.ptch;
    assign vld       = bus.vld;
    assign pwr_up    = bus.pwr_up;
    assign rider_off = bus.rider_off;

    // ------------------------------------------------------------------
    // Error saturation and proportional term
    // ------------------------------------------------------------------
    logic signed [9:0]  err_sat;
    logic signed [14:0] p_term;

    always_comb begin
        err_sat = ptch[9:0];
        if (ptch > 16'sd511) begin
            err_sat = 10'sd511;
        end else if (ptch < -16'sd512) begin
            err_sat = -10'sd512;
        end
    end

    assign p_term = $signed({{5{err_sat[9]}}, err_sat}) * $signed({10'd0, P_COEFF});

    // ------------------------------------------------------------------
    // Integrator with overflow hold
    // ------------------------------------------------------------------
    logic signed [17:0] integ_q, integ_d;
    logic signed [17:0] integ_sum;
    logic               integ_ovf;
    logic signed [11:0] i_term;

    assign integ_sum = integ_q + {{8{err_sat[9]}}, err_sat};
    assign integ_ovf = (integ_q[17] == err_sat[9]) && (integ_sum[17] != integ_q[17]);

    always_comb begin
        integ_d = integ_q;
        if (rider_off || !pwr_up) begin
            integ_d = '0;
        end else if (vld && !integ_ovf) begin
            integ_d = integ_sum;
        end
    end

    // Arithmetic shift by 6 of the post-update value is just its top 12 bits.
    assign i_term = integ_d[17:6];

    // ------------------------------------------------------------------
    // Derivative term
    // ------------------------------------------------------------------
    logic signed [9:0]  prev_err_q, prev_err_d;
    logic signed [10:0] d_raw;
    logic signed [6:0]  d_diff;
    logic signed [12:0] d_term;

    always_comb begin
        prev_err_d = prev_err_q;
        if (!pwr_up) begin
            prev_err_d = '0;
        end else if (vld) begin
            prev_err_d = err_sat;
        end
    end

    assign d_raw = {err_sat[9], err_sat} - {prev_err_q[9], prev_err_q};

    always_comb begin
        d_diff = d_raw[6:0];
        if (d_raw > 11'sd63) begin
            d_diff = 7'sd63;
        end else if (d_raw < -11'sd64) begin
            d_diff = -7'sd64;
        end
    end

    assign d_term = $signed({{6{d_diff[6]}}, d_diff}) * $signed({7'd0, D_COEFF});

    // ------------------------------------------------------------------
    // Soft-start counter
    // ------------------------------------------------------------------
    logic [7:0] ss_cnt_q, ss_cnt_d;

    always_comb begin
        ss_cnt_d = ss_cnt_q;
        if (!pwr_up) begin
            ss_cnt_d = '0;
        end else if (vld && (ss_cnt_q != 8'hff)) begin
            ss_cnt_d = ss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ_q    <= '0;
            prev_err_q <= '0;
            ss_cnt_q   <= '0;
        end else begin
            integ_q    <= integ_d;
            prev_err_q <= prev_err_d;
            ss_cnt_q   <= ss_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture terms and the pre-increment soft-start count
    // ------------------------------------------------------------------
    logic               s1_vld_q;
    logic signed [14:0] s1_p_q;
    logic signed [11:0] s1_i_q;
    logic signed [12:0] s1_d_q;
    logic [7:0]         s1_ss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_p_q   <= '0;
            s1_i_q   <= '0;
            s1_d_q   <= '0;
            s1_ss_q  <= '0;
        end else begin
            s1_vld_q <= vld;
            if (vld) begin
                s1_p_q  <= p_term;
                s1_i_q  <= i_term;
                s1_d_q  <= d_term;
                // A zero limit forces the output to 0 for samples taken while powered down.
                s1_ss_q <= pwr_up ? ss_cnt_q : 8'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: sum, saturate, soft-start clamp
    // ------------------------------------------------------------------
    logic signed [15:0] sum16;
    logic signed [11:0] sum_sat;
    logic signed [11:0] lim;
    logic signed [11:0] cntrl_nxt;

    assign sum16 = {s1_p_q[14], s1_p_q} + {{4{s1_i_q[11]}}, s1_i_q}
                 + {{3{s1_d_q[12]}}, s1_d_q};
    assign lim   = $signed({1'b0, s1_ss_q, 3'b000});

    always_comb begin
        sum_sat = sum16[11:0];
        if (sum16 > 16'sd2047) begin
            sum_sat = 12'sd2047;
        end else if (sum16 < -16'sd2048) begin
            sum_sat = -12'sd2048;
        end
    end

    always_comb begin
        cntrl_nxt = sum_sat;
        if (sum_sat > lim) begin
            cntrl_nxt = lim;
        end else if (sum_sat < -lim) begin
            cntrl_nxt = -lim;
        end
    end

    logic signed [11:0] pid_cntrl_q;
    logic               pid_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid_cntrl_q <= '0;
            pid_vld_q   <= 1'b0;
        end else begin
            pid_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                pid_cntrl_q <= cntrl_nxt;
            end
        end
    end

    assign bus.PID_cntrl = pid_cntrl_q;
    assign bus.PID_vld   = pid_vld_q;

endmodule

// File: tb/tb_balance_pid.sv
// Directed bench for balance_pid: hand-computed control words for soft start,
// steady state, saturation, integrator overflow, power-down and reset behaviour.
module tb_balance_pid;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    balance_pid_if bus ();

    balance_pid #(
        .P_COEFF (5'd12),
        .D_COEFF (6'd20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    // Called on a negedge; vld high across exactly one rising edge, returns on the next negedge.
    task automatic send_one(input logic [15:0] p);
        bus.vld  = 1'b1;
        bus.ptch = p;
        @(negedge clk);
        bus.vld  = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic stream_zeros();
        bus.vld  = 1'b1;
        bus.ptch = 16'h0000;
        repeat (255) @(negedge clk);
        bus.vld  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.vld       = 1'b0;
        bus.ptch      = '0;
        bus.pwr_up    = 1'b0;
        bus.rider_off = 1'b0;
        #1;
        n_cmp++; if (bus.PID_vld !== 1'b0) begin n_err++;
            $display("FAIL reset_vld: PID_vld=%b required 0", bus.PID_vld); end
        n_cmp++; if (bus.PID_cntrl !== 12'sd0) begin n_err++;
            $display("FAIL reset_cntrl: PID_cntrl=%0d required 0", bus.PID_cntrl); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_soft_start();
        bus.pwr_up = 1'b1;
        send_one(16'h0010);
        n_cmp++; if (bus.PID_vld !== 1'b0) begin n_err++;
            $display("FAIL ss_early_vld: PID_vld=%b required 0", bus.PID_vld); end
        @(negedge clk);
        n_cmp++; if (bus.PID_vld !== 1'b1) begin n_err++;
            $display("FAIL ss_first_vld: PID_vld=%b required 1", bus.PID_vld); end
        n_cmp++; if (bus.PID_cntrl !== 12'sd0) begin n_err++;
            $display("FAIL ss_first_cntrl: PID_cntrl=%0d required 0", bus.PID_cntrl); end
        @(negedge clk);
        n_cmp++; if (bus.PID_vld !== 1'b0) begin n_err++;
            $display("FAIL ss_pulse_width: PID_vld=%b required 0", bus.PID_vld); end
        send_one(16'h0010);
        @(negedge clk);
        n_cmp++; if (bus.PID_cntrl !== 12'sd8) begin n_err++;
            $display("FAIL ss_second_cntrl: PID_cntrl=%0d required 8", bus.PID_cntrl); end
    endtask

    task automatic test_steady_state();
        pulse_rst();
        bus.pwr_up    = 1'b1;
        bus.rider_off = 1'b0;
        stream_zeros();
        n_cmp++; if (bus.PID_cntrl !== 12'sd0) begin n_err++;
            $display("FAIL steady_zero: PID_cntrl=%0d required 0", bus.PID_cntrl); end
        send_one(16'h0010);
        @(negedge clk);
        n_cmp++; if (bus.PID_vld !== 1'b1) begin n_err++;
            $display("FAIL steady_vld: PID_vld=%b required 1", bus.PID_vld); end
        n_cmp++; if (bus.PID_cntrl !== 12'sd512) begin n_err++;
            $display("FAIL steady_cntrl: PID_cntrl=%0d required 512", bus.PID_cntrl); end
    endtask

    task automatic test_back_to_back();
        bus.vld  = 1'b1;
        bus.ptch = 16'h0020;
        @(negedge clk);
        bus.ptch = 16'hfff0;
        @(negedge clk);
        bus.vld  = 1'b0;
        n_cmp++; if (bus.PID_vld !== 1'b1 || bus.PID_cntrl !== 12'sd704) begin n_err++;
            $display("FAIL b2b_first: vld=%b cntrl=%0d required 1/704",
                     bus.PID_vld, bus.PID_cntrl); end
        @(negedge clk);
        n_cmp++; if (bus.PID_vld !== 1'b1 || bus.PID_cntrl !== -12'sd1152) begin n_err++;
            $display("FAIL b2b_second: vld=%b cntrl=%0d required 1/-1152",
                     bus.PID_vld, bus.PID_cntrl); end
        @(negedge clk);
        n_cmp++; if (bus.PID_vld !== 1'b0) begin n_err++;
            $display("FAIL b2b_drain: PID_vld=%b required 0", bus.PID_vld); end
    endtask

    task automatic test_pwr_down();
        bus.pwr_up = 1'b0;
        send_one(16'h0100);
        @(negedge clk);
        n_cmp++; if (bus.PID_vld !== 1'b1 || bus.PID_cntrl !== 12'sd0) begin n_err++;
            $display("FAIL pwr_down_out: vld=%b cntrl=%0d required 1/0",
                     bus.PID_vld, bus.PID_cntrl); end
        n_cmp++; if (dut.ss_cnt_q !== 8'd0 || dut.integ_q !== 18'sd0) begin n_err++;
            $display("FAIL pwr_down_state: ss_cnt=%0d integ=%0d required 0/0",
                     dut.ss_cnt_q, dut.integ_q); end
    endtask

    task automatic test_saturation();
        bus.pwr_up = 1'b1;
        stream_zeros();
        send_one(16'h7fff);
        @(negedge clk);
        n_cmp++; if (bus.PID_cntrl !== 12'sd2040) begin n_err++;
            $display("FAIL sat_pos: PID_cntrl=%0d required 2040", bus.PID_cntrl); end
        bus.rider_off = 1'b1;
        send_one(16'h0000);
        bus.rider_off = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.PID_cntrl !== -12'sd1280) begin n_err++;
            $display("FAIL sat_rezero: PID_cntrl=%0d required -1280", bus.PID_cntrl); end
        send_one(16'h8000);
        @(negedge clk);
        n_cmp++; if (bus.PID_cntrl !== -12'sd2040) begin n_err++;
            $display("FAIL sat_neg: PID_cntrl=%0d required -2040", bus.PID_cntrl); end
    endtask

    task automatic test_integ_overflow();
        bus.rider_off = 1'b1;
        @(negedge clk);
        bus.rider_off = 1'b0;
        bus.vld  = 1'b1;
        bus.ptch = 16'h01ff;
        repeat (257) @(negedge clk);
        bus.vld  = 1'b0;
        n_cmp++; if (dut.integ_q !== 18'sd130816) begin n_err++;
            $display("FAIL ovf_hold: integ=%0d required 130816", dut.integ_q); end
        @(negedge clk);
        send_one(16'h0000);
        @(negedge clk);
        n_cmp++; if (bus.PID_cntrl !== 12'sd764) begin n_err++;
            $display("FAIL ovf_iterm: PID_cntrl=%0d required 764", bus.PID_cntrl); end
    endtask

    task automatic test_rider_off();
        bus.rider_off = 1'b1;
        @(negedge clk);
        bus.rider_off = 1'b0;
        n_cmp++; if (dut.integ_q !== 18'sd0) begin n_err++;
            $display("FAIL rider_clear: integ=%0d required 0", dut.integ_q); end
        send_one(16'h0000);
        @(negedge clk);
        n_cmp++; if (bus.PID_vld !== 1'b1 || bus.PID_cntrl !== 12'sd0) begin n_err++;
            $display("FAIL rider_out: vld=%b cntrl=%0d required 1/0",
                     bus.PID_vld, bus.PID_cntrl); end
    endtask

    task automatic test_reset_mid_pipeline();
        send_one(16'h0010);
        @(negedge clk);
        n_cmp++; if (bus.PID_cntrl !== 12'sd512) begin n_err++;
            $display("FAIL mid_pre: PID_cntrl=%0d required 512", bus.PID_cntrl); end
        send_one(16'h0020);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.PID_cntrl !== 12'sd0 || bus.PID_vld !== 1'b0) begin n_err++;
            $display("FAIL mid_async: vld=%b cntrl=%0d required 0/0",
                     bus.PID_vld, bus.PID_cntrl); end
        n_cmp++; if (dut.ss_cnt_q !== 8'd0 || dut.prev_err_q !== 10'sd0) begin n_err++;
            $display("FAIL mid_state: ss_cnt=%0d prev_err=%0d required 0/0",
                     dut.ss_cnt_q, dut.prev_err_q); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.PID_vld !== 1'b0 || bus.PID_cntrl !== 12'sd0) begin n_err++;
                $display("FAIL mid_after_%0d: vld=%b cntrl=%0d required 0/0",
                         i, bus.PID_vld, bus.PID_cntrl); end
            @(negedge clk);
        end
        send_one(16'h0010);
        @(negedge clk);
        n_cmp++; if (bus.PID_vld !== 1'b1 || bus.PID_cntrl !== 12'sd0) begin n_err++;
            $display("FAIL first_after_rst: vld=%b cntrl=%0d required 1/0",
                     bus.PID_vld, bus.PID_cntrl); end
    endtask

    initial begin
        test_reset();
        test_soft_start();
        test_steady_state();
        test_back_to_back();
        test_pwr_down();
        test_saturation();
        test_integ_overflow();
        test_rider_off();
        test_reset_mid_pipeline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
